// File: rtl/imem_loader_if.sv
// imem_loader_if: start/UART/instruction-memory signal bundle for the loader
interface imem_loader_if #(parameter int addr_size = 10);
  logic                 start;
  logic [addr_size-1:0] word_count;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 tx_busy;
  logic [addr_size-1:0] mem_addr;
  logic [31:0]          mem_data;
  logic                 mem_we;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 busy;
  logic                 done;
  modport master (
    output start, word_count, rx_data, rx_valid, tx_busy,
    input  mem_addr, mem_data, mem_we, tx_data, tx_start, busy, done
  );
  modport slave (
    input  start, word_count, rx_data, rx_valid, tx_busy,
    output mem_addr, mem_data, mem_we, tx_data, tx_start, busy, done
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian UART bytes into 32-bit words, writes them to instruction memory, then sends an ack byte
module imem_loader #(
  parameter int         addr_size = 10,
  parameter logic [7:0] ack_byte  = 8'hAA
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, ACK, FINISH} state_t;
  state_t               state_q, state_d;
  logic [addr_size-1:0] addr_q, addr_d, len_q, len_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [23:0]          word_q, word_d;
  logic [addr_size-1:0] mem_addr_q;
  logic [31:0]          mem_data_q;
  logic                 mem_we_q, tx_start_q, busy_q, done_q;
  logic [7:0]           tx_data_q;
  // next-state and datapath: only the first three bytes are kept; the fourth goes straight to mem_data
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (bus.start) begin
        len_d   = bus.word_count;
        addr_d  = '0;
        cnt_d   = '0;
        state_d = (bus.word_count == '0) ? ACK : RECV;
      end
      RECV: if (bus.rx_valid) begin
        word_d  = {word_q[15:0], bus.rx_data};
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? WRITE : RECV;
      end
      WRITE: begin
        state_d = (addr_q == len_q - 1'b1) ? ACK : RECV;
        addr_d  = (addr_q == len_q - 1'b1) ? addr_q : addr_q + 1'b1;
      end
      ACK:     state_d = bus.tx_busy ? ACK : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and session datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end
  // registered outputs: mem_we is high exactly while in WRITE, tx_start in the cycle after ACK sees tx_busy low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_we_q   <= state_d == WRITE;
      tx_start_q <= state_q == ACK && !bus.tx_busy;
      if (state_d == WRITE) begin
        mem_addr_q <= addr_q;
        mem_data_q <= {word_q, bus.rx_data};
      end
      if (state_q == ACK && !bus.tx_busy) tx_data_q <= ack_byte;
      if (state_q == IDLE && bus.start) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else if (state_q == FINISH) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scenario tests of imem_loader against a queue-based word/ack model
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  imem_loader_if #(.addr_size(10)) bus();
  imem_loader #(.addr_size(10), .ack_byte(8'hAA)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [41:0] wr_q[$];
  logic [41:0] exp_q[$];
  int tx_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  int viol = 0;
  logic prev_we = 1'b0;
  logic prev_tx = 1'b0;

  // observe writes and ack launches away from the active edge
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_data});
    if (bus.tx_start === 1'b1) begin
      tx_cnt++;
      last_tx = bus.tx_data;
    end
    if ((bus.mem_we && bus.tx_start) || (bus.mem_we && prev_we) || (bus.tx_start && prev_tx)) viol++;
    prev_we = bus.mem_we;
    prev_tx = bus.tx_start;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs;
    wr_q.delete();
    tx_cnt = 0;
    last_tx = 8'h00;
  endtask

  // reference: every complete group of 4 accepted bytes becomes one big-endian word at consecutive addresses
  function automatic void model(input logic [7:0] b[$]);
    exp_q.delete();
    for (int i = 0; i < b.size() / 4; i++)
      exp_q.push_back({10'(i), b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
  endfunction

  task automatic start_session(input int n);
    bus.word_count = 10'(n);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick;
    bus.rx_valid = 1'b0;
    repeat (gap) tick;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.done === 1'b1 && bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_addr, bus.mem_data, bus.mem_we, bus.tx_data, bus.tx_start, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h data=%h we=%b txd=%h txs=%b busy=%b done=%b exp all 0",
               bus.mem_addr, bus.mem_data, bus.mem_we, bus.tx_data, bus.tx_start, bus.busy, bus.done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic;
    logic [7:0] b[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    bit ok;
    clear_obs;
    model(b);
    start_session(2);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      errors++;
      $display("FAIL basic_busy_rise got busy=%b done=%b exp 1 0", bus.busy, bus.done);
    end
    for (int i = 0; i < 4; i++) send_byte(b[i], 0);
    @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_data} !== {1'b1, 10'd0, 32'h12345678}) begin
      errors++;
      $display("FAIL basic_we_timing got we=%b addr=%h data=%h exp 1 000 12345678", bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    tick;
    for (int i = 4; i < 8; i++) send_byte(b[i], 0);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout got busy=%b done=%b exp 0 1", bus.busy, bus.done);
    end
    checks++;
    if (wr_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_nwrites got %0d exp %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_write%0d got %h exp %h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tx_cnt !== 1 || last_tx !== 8'hAA) begin
      errors++;
      $display("FAIL basic_ack got count=%0d byte=%h exp 1 aa", tx_cnt, last_tx);
    end
  endtask

  task automatic test_zero;
    bit ok;
    int seen;
    clear_obs;
    start_session(0);
    seen = 0;
    @(negedge clk);
    if (bus.tx_start === 1'b1) seen++;
    @(negedge clk);
    if (bus.tx_start === 1'b1) seen++;
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("FAIL zero_ack_latency got %0d pulses in 2 cycles exp 1", seen);
    end
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() !== 0 || tx_cnt !== 1 || last_tx !== 8'hAA) begin
      errors++;
      $display("FAIL zero_session got ok=%b writes=%0d acks=%0d byte=%h exp 1 0 1 aa", ok, wr_q.size(), tx_cnt, last_tx);
    end
  endtask

  task automatic test_tx_busy;
    logic [7:0] b[$];
    bit ok;
    clear_obs;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    model(b);
    bus.tx_busy = 1'b1;
    start_session(1);
    for (int i = 0; i < 4; i++) send_byte(b[i], 0);
    repeat (20) tick;
    checks++;
    if (tx_cnt !== 0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL txbusy_hold got acks=%0d busy=%b exp 0 1", tx_cnt, bus.busy);
    end
    bus.tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL txbusy_fall_cycle got tx_start=%b exp 0", bus.tx_start);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.tx_start !== 1'b1) begin
      errors++;
      $display("FAIL txbusy_next_cycle got tx_start=%b exp 1", bus.tx_start);
    end
    wait_idle(ok);
    checks++;
    if (!ok || tx_cnt !== 1 || wr_q.size() !== 1 || wr_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL txbusy_session got ok=%b acks=%0d writes=%0d exp 1 1 1", ok, tx_cnt, wr_q.size());
    end
  endtask

  task automatic test_ignore;
    logic [7:0] b[$];
    bit ok;
    clear_obs;
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    model(b);
    start_session(2);
    send_byte(b[0], 0);
    send_byte(b[1], 0);
    bus.word_count = 10'd5;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    send_byte(b[2], 0);
    send_byte(b[3], 0);
    send_byte(8'h5A, 0);
    for (int i = 4; i < 8; i++) send_byte(b[i], 0);
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL ignore_nwrites got ok=%b writes=%0d exp 1 %0d", ok, wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_write%0d got %h exp %h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tx_cnt !== 1) begin
      errors++;
      $display("FAIL ignore_ack got %0d exp 1", tx_cnt);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    clear_obs;
    start_session(3);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3 ? 1 : 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_addr, bus.mem_data, bus.mem_we, bus.tx_data, bus.tx_start, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got addr=%h data=%h we=%b txd=%h txs=%b busy=%b done=%b exp all 0",
               bus.mem_addr, bus.mem_data, bus.mem_we, bus.tx_data, bus.tx_start, bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() !== 1) begin
      errors++;
      $display("FAIL midreset_prior_writes got %0d exp 1", wr_q.size());
    end
    clear_obs;
    reset = 1'b0;
    bus.word_count = 10'd1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_first_edge_start got busy=%b exp 1", bus.busy);
    end
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() !== 1 || wr_q[0] !== {10'd0, 32'hDEADBEEF} || tx_cnt !== 1) begin
      errors++;
      $display("FAIL midreset_new_session got ok=%b writes=%0d first=%h acks=%0d exp 1 1 000deadbeef 1",
               ok, wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 42'h0, tx_cnt);
    end
  endtask

  task automatic test_done_restart;
    logic [7:0] b[$];
    bit ok;
    clear_obs;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    model(b);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done_sticky got %b exp 1", bus.done);
    end
    start_session(1);
    checks++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL restart_same_edge got done=%b busy=%b exp 0 1", bus.done, bus.busy);
    end
    for (int i = 0; i < 4; i++) send_byte(b[i], 0);
    wait_idle(ok);
    checks++;
    if (!ok || wr_q.size() !== 1 || wr_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL restart_session got ok=%b writes=%0d exp 1 1", ok, wr_q.size());
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 6; s++) begin
      logic [7:0] b[$];
      bit ok;
      int n;
      clear_obs;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
      model(b);
      send_byte(8'($urandom), 1);
      bus.tx_busy = 1'($urandom_range(0, 1));
      start_session(n);
      for (int i = 0; i < 4 * n; i++) send_byte(b[i], (i % 4 == 3) ? $urandom_range(1, 2) : $urandom_range(0, 2));
      repeat ($urandom_range(0, 5)) tick;
      bus.tx_busy = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || wr_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL random%0d_nwrites got ok=%b writes=%0d exp 1 %0d", s, ok, wr_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d_write%0d got %h exp %h", s, i, wr_q[i], exp_q[i]);
        end
      end
      checks++;
      if (tx_cnt !== 1 || last_tx !== 8'hAA) begin
        errors++;
        $display("FAIL random%0d_ack got count=%0d byte=%h exp 1 aa", s, tx_cnt, last_tx);
      end
    end
  endtask

  task automatic test_strobes;
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_overlap got %0d violations exp 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_tx_busy;
    test_ignore;
    test_reset_mid;
    test_done_restart;
    test_random;
    test_strobes;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter addr_size, default 10, SHALL set the instruction-memory word address width.
REQ-002 Parameter ack_byte, default 8'hAA, SHALL be the completion byte sent to the UART transmitter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new load session when sampled high in IDLE.
REQ-006 word_count  input  addr_size  SHALL give the number of 32-bit words to load; it is sampled with start.
REQ-007 rx_data  input  8  SHALL carry the received UART byte.
REQ-008 rx_valid  input  1  SHALL be a one-cycle strobe marking rx_data valid.
REQ-009 tx_busy  input  1  SHALL indicate that the UART transmitter cannot accept a byte.
REQ-010 mem_addr  output  addr_size  SHALL carry the instruction-memory write address.
REQ-011 mem_data  output  32  SHALL carry the instruction-memory write data.
REQ-012 mem_we  output  1  SHALL be the instruction-memory write enable, one cycle per word.
REQ-013 tx_data  output  8  SHALL carry the completion byte.
REQ-014 tx_start  output  1  SHALL be a one-cycle strobe that launches tx_data.
REQ-015 busy  output  1  SHALL be high from session start until the completion byte is launched.
REQ-016 done  output  1  SHALL be a sticky flag: set when a session completes, cleared by the next accepted start.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, RECV, WRITE, ACK and FINISH.
REQ-018 IDLE, start=1, word_count!=0 -> RECV: latch word_count; addr<=0; byte_cnt<=0; busy<=1; done<=0.
REQ-019 IDLE, start=1, word_count=0 -> ACK with busy<=1 and done<=0; no memory write SHALL occur.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 RECV, rx_valid=1 -> word<={word[23:0],rx_data} (MSB byte first, big-endian) and byte_cnt increments modulo 4.
REQ-022 RECV -> WRITE on the cycle the 4th byte of a word is accepted.
REQ-023 WRITE SHALL last one cycle, with mem_we=1, mem_addr=addr and mem_data=word, so that mem_we rises one cycle after the 4th rx_valid.
REQ-024 WRITE -> ACK if addr equals latched word_count-1; otherwise addr<=addr+1 and the FSM SHALL go to RECV.
REQ-025 rx_valid SHALL be ignored outside RECV; ignored bytes SHALL not be counted or stored.
REQ-026 ACK SHALL wait while tx_busy=1.
REQ-027 ACK with tx_busy=0 SHALL pulse tx_start for one cycle with tx_data=ack_byte, then go to FINISH.
REQ-028 FINISH SHALL set done<=1 and busy<=0, then go to IDLE after one cycle.
REQ-029 mem_we and tx_start SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-030 When mem_we=0, mem_addr and mem_data SHALL hold their last values.
REQ-031 Address arithmetic SHALL be unsigned, addr_size bits wide; the maximum session is 2^addr_size-1 words and addr SHALL never wrap within a session.

Reset
REQ-032 While reset=1, state SHALL be IDLE and the following SHALL be 0: mem_addr, mem_data, mem_we, tx_data, tx_start, busy, done, byte_cnt and the word register.
REQ-033 Reset asserted mid-session SHALL abort the session immediately and asynchronously; partially assembled bytes SHALL be discarded and no further mem_we SHALL occur.
REQ-034 After reset deassertion, the block SHALL accept start on the first rising clock edge.

Verification
REQ-035 word_count=2, bytes 12 34 56 78 9A BC DE F0 -> mem_we at addr 0 with data 32'h12345678, then at addr 1 with data 32'h9ABCDEF0; tx_start with tx_data=8'hAA; done=1, busy=0.
REQ-036 word_count=0 -> no mem_we; tx_start with 8'hAA within 2 cycles of start; done=1.
REQ-037 tx_busy held high for 20 cycles after the last write -> tx_start stays low, then pulses exactly once, on the cycle after tx_busy falls.
REQ-038 start pulsed during RECV, and rx_valid pulsed during WRITE -> both ignored; the word assembled from RECV-state bytes (big-endian) is written, the extra byte is not counted, and the addresses are unchanged.
REQ-039 reset asserted after 2 of 4 bytes of word 1, then a new session with word_count=1, bytes DE AD BE EF -> all outputs 0 during reset; exactly one write of 32'hDEADBEEF at addr 0.
REQ-040 done=1 from a previous session, then start -> done clears on the accepted start and busy rises on the same edge.
